// File: rtl/trigger_conditioner.sv
// Trigger conditioner: synchronises an asynchronous trigger source, debounces it
// with a programmable stability window and emits a clean level plus one-cycle
// rise/fall strobes. Aborted qualifications are counted in a saturating counter.
module trigger_conditioner #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,       // asynchronous, active low
  input  logic             i_raw_in,
  input  logic             i_invert,
  input  logic [CNT_W-1:0] i_debounce_len,
  input  logic             i_glitch_clr,
  output logic             o_trigger,
  output logic             o_rise_pulse,
  output logic             o_fall_pulse,
  output logic [7:0]       o_glitch_cnt
);

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    StIdleLow,
    StQualHigh,
    StIdleHigh,
    StQualLow
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       r_len;
  logic                   r_trigger;
  logic                   r_rise;
  logic                   r_fall;
  logic [7:0]             r_glitch;

  logic                   w_src;
  logic                   w_s;
  logic [CNT_W-1:0]       w_len_eff;
  logic [CNT_W-1:0]       w_cnt_inc;
  state_t                 w_state_nxt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic [CNT_W-1:0]       w_len_nxt;
  logic                   w_trigger_nxt;
  logic                   w_rise_nxt;
  logic                   w_fall_nxt;
  logic                   w_abort;
  logic [7:0]             w_glitch_nxt;

  // Inversion happens ahead of the synchroniser so an invert toggle is debounced too.
  assign w_src     = i_raw_in ^ i_invert;
  assign w_s       = r_sync[SYNC_STAGES-1];
  assign w_len_eff = (i_debounce_len == '0) ? CntOne : i_debounce_len;
  assign w_cnt_inc = r_cnt + CntOne;

  // Synchroniser shift chain; the last stage feeds the debouncer.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], w_src};
    end
  end

  // Debounce FSM next-state logic; commit and abort decisions use the current s.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_len_nxt     = r_len;
    w_trigger_nxt = r_trigger;
    w_rise_nxt    = 1'b0;
    w_fall_nxt    = 1'b0;
    w_abort       = 1'b0;
    unique case (r_state)
      StIdleLow: begin
        if (w_s) begin
          if (w_len_eff == CntOne) begin
            w_state_nxt   = StIdleHigh;
            w_trigger_nxt = 1'b1;
            w_rise_nxt    = 1'b1;
            w_cnt_nxt     = '0;
          end else begin
            w_state_nxt = StQualHigh;
            w_cnt_nxt   = CntOne;
            w_len_nxt   = w_len_eff;
          end
        end
      end
      StQualHigh: begin
        if (!w_s) begin
          w_state_nxt = StIdleLow;
          w_cnt_nxt   = '0;
          w_abort     = 1'b1;
        end else if (w_cnt_inc == r_len) begin
          w_state_nxt   = StIdleHigh;
          w_trigger_nxt = 1'b1;
          w_rise_nxt    = 1'b1;
          w_cnt_nxt     = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      StIdleHigh: begin
        if (!w_s) begin
          if (w_len_eff == CntOne) begin
            w_state_nxt   = StIdleLow;
            w_trigger_nxt = 1'b0;
            w_fall_nxt    = 1'b1;
            w_cnt_nxt     = '0;
          end else begin
            w_state_nxt = StQualLow;
            w_cnt_nxt   = CntOne;
            w_len_nxt   = w_len_eff;
          end
        end
      end
      StQualLow: begin
        if (w_s) begin
          w_state_nxt = StIdleHigh;
          w_cnt_nxt   = '0;
          w_abort     = 1'b1;
        end else if (w_cnt_inc == r_len) begin
          w_state_nxt   = StIdleLow;
          w_trigger_nxt = 1'b0;
          w_fall_nxt    = 1'b1;
          w_cnt_nxt     = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      default: begin
        w_state_nxt   = StIdleLow;
        w_cnt_nxt     = '0;
        w_trigger_nxt = 1'b0;
      end
    endcase
  end

  // Glitch counter next value: clear wins over a same-cycle abort, no wrap at 255.
  always_comb begin
    w_glitch_nxt = r_glitch;
    if (i_glitch_clr) begin
      w_glitch_nxt = '0;
    end else if (w_abort && (r_glitch != 8'hFF)) begin
      w_glitch_nxt = r_glitch + 8'd1;
    end
  end

  // FSM, counters and registered outputs.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state   <= StIdleLow;
      r_cnt     <= '0;
      r_len     <= CntOne;
      r_trigger <= 1'b0;
      r_rise    <= 1'b0;
      r_fall    <= 1'b0;
      r_glitch  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_len     <= w_len_nxt;
      r_trigger <= w_trigger_nxt;
      r_rise    <= w_rise_nxt;
      r_fall    <= w_fall_nxt;
      r_glitch  <= w_glitch_nxt;
    end
  end

  assign o_trigger    = r_trigger;
  assign o_rise_pulse = r_rise;
  assign o_fall_pulse = r_fall;
  assign o_glitch_cnt = r_glitch;

endmodule

// File: tb/tb_trigger_conditioner.sv
// Bench for trigger_conditioner: directed scenarios plus random bouncing input,
// checked cycle by cycle against a run-length model of the debounce rules.
module tb_trigger_conditioner;

  localparam int unsigned SyncStages = 2;
  localparam int unsigned CntW       = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            raw_in = 1'b0;
  logic            invert = 1'b0;
  logic [CntW-1:0] debounce_len = 8'd3;
  logic            glitch_clr = 1'b0;
  logic            trigger;
  logic            rise_pulse;
  logic            fall_pulse;
  logic [7:0]      glitch_cnt;

  trigger_conditioner #(
    .SYNC_STAGES(SyncStages),
    .CNT_W      (CntW)
  ) dut (
    .i_clk         (clk),
    .i_reset       (rst_n),
    .i_raw_in      (raw_in),
    .i_invert      (invert),
    .i_debounce_len(debounce_len),
    .i_glitch_clr  (glitch_clr),
    .o_trigger     (trigger),
    .o_rise_pulse  (rise_pulse),
    .o_fall_pulse  (fall_pulse),
    .o_glitch_cnt  (glitch_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       trig;
    logic       rise;
    logic       fall;
    logic [7:0] glitch;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: source history, committed level, length of the
  // current run of samples that disagree with it, and the latched window.
  bit   hist[$];
  bit   m_trig;
  int   m_run;
  int   m_len;
  int   m_glitch;
  int   m_rises = 0;
  int   dut_rises = 0;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s t=%0t got=%0d want=%0d", name, $time, got, want);
    end
  endtask

  task automatic model_step();
    exp_t e;
    bit   s;
    bit   abort;
    e = '0;
    if (!rst_n) begin
      m_trig   = 1'b0;
      m_run    = 0;
      m_len    = 1;
      m_glitch = 0;
      hist     = {};
      for (int i = 0; i < SyncStages; i++) hist.push_back(1'b0);
    end else begin
      // A source value sampled at edge n is acted on at edge n+SyncStages.
      s     = hist.pop_front();
      hist.push_back(raw_in ^ invert);
      abort = 1'b0;
      if (s != m_trig) begin
        if (m_run == 0) m_len = (debounce_len == 0) ? 1 : int'(debounce_len);
        m_run++;
        if (m_run == m_len) begin
          m_trig = s;
          e.rise = s;
          e.fall = !s;
          m_run  = 0;
          if (s) m_rises++;
        end
      end else if (m_run > 0) begin
        abort = 1'b1;
        m_run = 0;
      end
      if (glitch_clr) m_glitch = 0;
      else if (abort && m_glitch < 255) m_glitch++;
    end
    e.trig   = m_trig;
    e.glitch = 8'(m_glitch);
    sb.push_back(e);
  endtask

  // Model runs on the same edge the DUT registers.
  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Monitor: samples just after each edge and pops the expected response.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rise_pulse) dut_rises++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty t=%0t got=nothing want=entry", $time);
      end else begin
        e = sb.pop_front();
        if ({trigger, rise_pulse, fall_pulse, glitch_cnt} !== e) begin
          errors++;
          $display("FAIL outputs t=%0t got trig=%0b rise=%0b fall=%0b glitch=%0d want trig=%0b rise=%0b fall=%0b glitch=%0d",
                   $time, trigger, rise_pulse, fall_pulse, glitch_cnt,
                   e.trig, e.rise, e.fall, e.glitch);
        end
      end
      if (rise_pulse && fall_pulse) begin
        errors++;
        $display("FAIL both_pulses t=%0t got rise=1 fall=1 want not both", $time);
      end
    end
  end

  // Drive raw_in at the current negedge and hold it for n cycles.
  task automatic hold(input bit v, input int n);
    raw_in = v;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // Reset with a low source and a 3-sample window.
    repeat (3) @(negedge clk);
    check("reset_trigger", int'(trigger), 0);
    check("reset_glitch", int'(glitch_cnt), 0);
    rst_n = 1'b1;
    hold(1'b0, 20);
    check("idle_low_trigger", int'(trigger), 0);

    // Clean rise and fall with a 3-sample window.
    hold(1'b1, 20);
    check("clean_rise_level", int'(trigger), 1);
    hold(1'b0, 20);
    check("clean_fall_level", int'(trigger), 0);

    // Bounce on the rise with a 4-sample window.
    debounce_len = 8'd4;
    hold(1'b1, 2);
    hold(1'b0, 1);
    hold(1'b1, 15);
    check("bounce_glitch", int'(glitch_cnt), 1);
    hold(1'b0, 15);

    // Windows of 0 and 1: every change of s commits on the next edge.
    for (int l = 0; l < 2; l++) begin
      debounce_len = 8'(l);
      for (int k = 0; k < 8; k++) hold(k[0] ? 1'b0 : 1'b1, 1 + int'($urandom_range(0, 3)));
      hold(1'b0, 6);
    end

    // 260 one-cycle glitches saturate the counter.
    debounce_len = 8'd2;
    for (int k = 0; k < 260; k++) begin
      hold(1'b1, 1);
      hold(1'b0, 1);
    end
    hold(1'b0, 4);
    check("glitch_saturated", int'(glitch_cnt), 255);

    // Clear held across a further abort: clear wins.
    glitch_clr = 1'b1;
    hold(1'b1, 1);
    hold(1'b0, 4);
    glitch_clr = 1'b0;
    hold(1'b0, 2);
    check("glitch_cleared", int'(glitch_cnt), 0);

    // Reset in the middle of a rising qualification.
    debounce_len = 8'd5;
    hold(1'b1, 4);
    rst_n = 1'b0;
    #1;
    check("midqual_reset_trigger", int'(trigger), 0);
    check("midqual_reset_rise", int'(rise_pulse), 0);
    check("midqual_reset_glitch", int'(glitch_cnt), 0);
    @(negedge clk);
    @(negedge clk);
    raw_in = 1'b0;
    invert = 1'b1;
    rst_n  = 1'b1;
    hold(1'b0, 20);
    check("inverted_source_level", int'(trigger), 1);
    invert = 1'b0;
    hold(1'b0, 20);

    // Random bouncing source with changing window, invert and clears.
    for (int seg = 0; seg < 300; seg++) begin
      if ($urandom_range(0, 3) == 0) debounce_len = 8'($urandom_range(0, 5));
      if ($urandom_range(0, 9) == 0) invert = ~invert;
      glitch_clr = ($urandom_range(0, 19) == 0);
      hold(1'($urandom_range(0, 1)), 1 + int'($urandom_range(0, 7)));
    end
    glitch_clr = 1'b0;
    hold(raw_in, 12);

    check("rise_pulse_count", dut_rises, m_rises);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/trigger_conditioner.md
Name: trigger_conditioner

Overview:
Upstream input stage for the digital delay timer. It takes an asynchronous, bouncy trigger source, synchronises it, debounces it with a programmable stability window, and drives a clean level plus single-cycle edge strobes into the timer's trigger input. It also keeps a saturating count of rejected glitches for status readout.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops on raw_in (legal range 2..4).
CNT_W, 8, width of debounce_len and of the internal stability counter.

Ports:
clk  input  1  single system clock, rising-edge active.
reset  input  1  asynchronous, active-low reset.
raw_in  input  1  asynchronous raw trigger source.
invert  input  1  1 = use ~raw_in as the source level (applied before the synchroniser).
debounce_len  input  CNT_W  required number of consecutive stable samples; 0 is treated as 1.
glitch_clr  input  1  synchronous clear of glitch_cnt.
trigger  output  1  debounced level; feeds the delay timer's trigger.
rise_pulse  output  1  one-cycle strobe when trigger goes 0->1.
fall_pulse  output  1  one-cycle strobe when trigger goes 1->0.
glitch_cnt  output  8  saturating count of aborted qualifications.

Behaviour:
- Reset (reset=0, asynchronous):
  - All synchroniser flops are 0.
  - FSM goes to IDLE_LOW and the stability counter is 0.
  - trigger=0, rise_pulse=0, fall_pulse=0, glitch_cnt=0.
  - Reset asserted mid-qualification aborts it with no pulse and no glitch increment.
- Synchroniser: the source (raw_in XOR invert) passes through SYNC_STAGES flops. The last stage output is s.
  - A change of source that is set up before edge E0 appears on s after edge E0+SYNC_STAGES-1.
- len_eff = max(debounce_len, 1).
  - Latched into an internal register on entry to a QUAL state.
  - Changes to debounce_len during qualification have no effect until the next qualification.
- FSM states: IDLE_LOW, QUAL_HIGH, IDLE_HIGH, QUAL_LOW. All transitions happen on clk edges and use the value of s at that edge.
- IDLE_LOW:
  - s=1 and len_eff=1 -> IDLE_HIGH; trigger<=1, rise_pulse<=1.
  - s=1 and len_eff>1 -> QUAL_HIGH; cnt<=1.
  - s=0 -> stay.
- QUAL_HIGH:
  - s=0 -> IDLE_LOW; glitch increment.
  - s=1 and cnt+1==len_eff -> IDLE_HIGH; trigger<=1, rise_pulse<=1.
  - Otherwise cnt<=cnt+1.
- IDLE_HIGH and QUAL_LOW mirror IDLE_LOW and QUAL_HIGH with the polarity swapped:
  - Commit sets trigger<=0 and fall_pulse<=1.
  - Abort returns to IDLE_HIGH with a glitch increment.
- Latency: trigger changes after edge E0+SYNC_STAGES+len_eff-1, given a clean, stable source.
- Pulses:
  - Registered, high for exactly one cycle, coincident with the first cycle of the new trigger level.
  - rise_pulse and fall_pulse are never high together.
- Counter arithmetic: cnt is CNT_W bits and never wraps, because len_eff ≤ 2^CNT_W-1 bounds it.
- glitch_cnt:
  - Each abort adds 1, saturating at 255 (no wrap).
  - glitch_clr=1 sets it to 0 on the next edge.
  - Clear takes priority over a simultaneous increment, so the result is 0.
- invert toggle: treated as a source transition and debounced like any other; no special bypass.
- Source high when reset is released: qualifies normally and produces rise_pulse after the standard latency.

Test Plan:
- Reset release with raw_in=0, invert=0, debounce_len=3: trigger, pulses and glitch_cnt stay 0 indefinitely.
- raw_in 0->1 set up before edge 10, SYNC_STAGES=2, debounce_len=3, then held:
  - trigger=1 from edge 14.
  - rise_pulse=1 only in the cycle after edge 14.
  - Release at edge 30 gives trigger=0 and fall_pulse after edge 34.
- Bounce on the rise, debounce_len=4: raw_in high for 2 cycles, low for 1, then held high:
  - glitch_cnt=1.
  - Exactly one rise_pulse, 4 samples after the final stable rise reaches s.
- debounce_len=0 and =1: trigger follows s one edge later; each edge gives exactly one pulse.
- 260 aborted one-cycle glitches: glitch_cnt saturates at 255. Then glitch_clr asserted in the same cycle as a further abort gives glitch_cnt=0.
- Reset asserted in the middle of QUAL_HIGH: outputs are 0 immediately with no rise_pulse. With invert=1 and raw_in=0 after release: trigger rises after SYNC_STAGES+len_eff-1 edges.
